// File: rtl/spi_sram_pkg.sv
// Shared definitions for the SPI SRAM read cache: FSM states and default
// address-field widths for the cpu_6502 / spi_sram_master pairing.
package spi_sram_pkg;

  localparam int ADDR_W_DEF     = 16;
  localparam int LINES_DEF      = 8;
  localparam int LINE_BYTES_DEF = 4;
  localparam int MEM_ADDR_W     = 24;

  localparam int OFF_W = $clog2(LINE_BYTES_DEF);
  localparam int IDX_W = $clog2(LINES_DEF);
  localparam int TAG_W = ADDR_W_DEF - IDX_W - OFF_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FILL  = 2'd2
  } cache_state_e;

endpackage

// File: rtl/cache_line_store.sv
// Direct-mapped line storage: flop arrays for data/tag/valid, combinational
// lookup, plus fill, write-hit, tag-install and flush write ports.
module cache_line_store #(
  parameter int LINES      = 8,
  parameter int LINE_BYTES = 4,
  parameter int TAG_BITS   = 11,
  parameter int IDX_BITS   = $clog2(LINES),
  parameter int OFF_BITS   = $clog2(LINE_BYTES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush_i,
  input  logic [IDX_BITS-1:0] lk_idx_i,
  input  logic [OFF_BITS-1:0] lk_off_i,
  input  logic [TAG_BITS-1:0] lk_tag_i,
  output logic                hit_o,
  output logic [7:0]          rdata_o,
  input  logic                fill_we_i,
  input  logic [IDX_BITS-1:0] fill_idx_i,
  input  logic [OFF_BITS-1:0] fill_off_i,
  input  logic [7:0]          fill_data_i,
  input  logic                wr_we_i,
  input  logic [IDX_BITS-1:0] wr_idx_i,
  input  logic [OFF_BITS-1:0] wr_off_i,
  input  logic [7:0]          wr_data_i,
  input  logic                tag_we_i,
  input  logic [IDX_BITS-1:0] tag_idx_i,
  input  logic [TAG_BITS-1:0] tag_i,
  input  logic                valid_set_i
);

  logic [7:0]          data_q [LINES][LINE_BYTES];
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [LINES-1:0]    valid_q;

  assign hit_o   = valid_q[lk_idx_i] && (tag_q[lk_idx_i] == lk_tag_i);
  assign rdata_o = data_q[lk_idx_i][lk_off_i];

  // Data and tag carry no reset; valid alone decides whether they mean anything.
  always_ff @(posedge clk) begin
    if (fill_we_i) begin
      data_q[fill_idx_i][fill_off_i] <= fill_data_i;
    end else if (wr_we_i) begin
      data_q[wr_idx_i][wr_off_i] <= wr_data_i;
    end
    if (tag_we_i) begin
      tag_q[tag_idx_i] <= tag_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (valid_set_i) begin
      valid_q[tag_idx_i] <= 1'b1;
    end
  end

endmodule

// File: rtl/spi_sram_cache.sv
// Direct-mapped write-through read cache between the 6502 bus and the SPI
// SRAM master; hits complete in the request cycle, misses fill a whole line.
module spi_sram_cache #(
  parameter int ADDR_W     = 16,
  parameter int MEM_ADDR_W = spi_sram_pkg::MEM_ADDR_W,
  parameter int LINES      = 8,
  parameter int LINE_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  cpu_en,
  input  logic                  cpu_wr,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [7:0]            cpu_wdata,
  output logic [7:0]            cpu_rdata,
  output logic                  cpu_ready,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  input  logic                  mem_ready
);
  import spi_sram_pkg::*;

  localparam int OFF_BITS = $clog2(LINE_BYTES);
  localparam int IDX_BITS = $clog2(LINES);
  localparam int TAG_BITS = ADDR_W - IDX_BITS - OFF_BITS;

  cache_state_e          state_q, state_d;
  logic [OFF_BITS-1:0]   cnt_q, cnt_d;
  logic                  abort_q, abort_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_wr_q, mem_wr_d;
  logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]            mem_wdata_q, mem_wdata_d;

  logic [OFF_BITS-1:0] cpu_off;
  logic [IDX_BITS-1:0] cpu_idx;
  logic [TAG_BITS-1:0] cpu_tag;
  logic [IDX_BITS-1:0] fill_idx;
  logic [TAG_BITS-1:0] fill_tag;
  logic                hit;
  logic [7:0]          line_rdata;
  logic                rd_hit;
  logic                beat;
  logic                fill_last;
  logic                wr_done;

  assign cpu_off = cpu_addr[OFF_BITS-1:0];
  assign cpu_idx = cpu_addr[OFF_BITS +: IDX_BITS];
  assign cpu_tag = cpu_addr[ADDR_W-1 -: TAG_BITS];

  // The line being filled is taken from the registered SRAM address so a
  // misbehaving CPU bus cannot redirect a fill halfway through.
  assign fill_idx = mem_addr_q[OFF_BITS +: IDX_BITS];
  assign fill_tag = mem_addr_q[OFF_BITS+IDX_BITS +: TAG_BITS];

  assign rd_hit    = (state_q == IDLE) && cpu_en && !cpu_wr && hit;
  assign beat      = (state_q == FILL) && mem_ready;
  assign fill_last = beat && (cnt_q == OFF_BITS'(LINE_BYTES - 1));
  assign wr_done   = (state_q == WRITE) && mem_ready;

  assign cpu_ready = rd_hit || wr_done;
  assign cpu_rdata = rd_hit ? line_rdata : 8'h00;

  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  cache_line_store #(
    .LINES      (LINES),
    .LINE_BYTES (LINE_BYTES),
    .TAG_BITS   (TAG_BITS),
    .IDX_BITS   (IDX_BITS),
    .OFF_BITS   (OFF_BITS)
  ) u_store (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .lk_idx_i    (cpu_idx),
    .lk_off_i    (cpu_off),
    .lk_tag_i    (cpu_tag),
    .hit_o       (hit),
    .rdata_o     (line_rdata),
    .fill_we_i   (beat),
    .fill_idx_i  (fill_idx),
    .fill_off_i  (cnt_q),
    .fill_data_i (mem_rdata),
    .wr_we_i     (wr_done && hit),
    .wr_idx_i    (cpu_idx),
    .wr_off_i    (cpu_off),
    .wr_data_i   (mem_wdata_q),
    .tag_we_i    (fill_last),
    .tag_idx_i   (fill_idx),
    .tag_i       (fill_tag),
    .valid_set_i (fill_last && !abort_q && !flush)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    abort_d     = abort_q;
    mem_en_d    = mem_en_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (cpu_en && cpu_wr) begin
          state_d     = WRITE;
          mem_en_d    = 1'b1;
          mem_wr_d    = 1'b1;
          mem_addr_d  = MEM_ADDR_W'(cpu_addr);
          mem_wdata_d = cpu_wdata;
        end else if (cpu_en && !hit) begin
          state_d    = FILL;
          cnt_d      = '0;
          abort_d    = 1'b0;
          mem_en_d   = 1'b1;
          mem_wr_d   = 1'b0;
          mem_addr_d = MEM_ADDR_W'({cpu_addr[ADDR_W-1:OFF_BITS], {OFF_BITS{1'b0}}});
        end
      end
      FILL: begin
        if (flush) begin
          abort_d = 1'b1;
        end
        if (mem_ready) begin
          cnt_d                     = cnt_q + 1'b1;
          mem_addr_d[OFF_BITS-1:0]  = cnt_q + 1'b1;
          if (fill_last) begin
            state_d  = IDLE;
            mem_en_d = 1'b0;
          end
        end
      end
      WRITE: begin
        if (mem_ready) begin
          state_d  = IDLE;
          mem_en_d = 1'b0;
          mem_wr_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      abort_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      abort_q     <= abort_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

endmodule
